// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge.
//   CMD_WRITE / CMD_READ : command byte values recognised in byte 0 of a frame
//   spi_bridge_state_t   : frame-level state of the bridge
package spi_reg_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR_DATA,
    RD_DATA,
    IGNORE
  } spi_bridge_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered rise/fall detection.
//   clk, reset : system clock, synchronous active-high reset (edge flags only)
//   din        : asynchronous input
//   level      : synchronized level, time-aligned with rise/fall
//   rise, fall : one-clk pulses on a synchronized 0->1 / 1->0 transition
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // The synchronizer chain is left out of reset so that a reset while the
  // input is low cannot fabricate an edge once reset releases.
  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], din};
    last_q <= sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync_q[STAGES-1] & ~last_q;
      fall <= ~sync_q[STAGES-1] & last_q;
    end
  end

  assign level = last_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns host frames into single-cycle register-bus
// accesses. Frame: command byte, start address byte, then data bytes until
// chip select rises; the address auto-increments through a burst.
//   clk, reset      : system clock (>=16x sclk), synchronous active-high reset
//   spi_sclk/csn/mosi : SPI inputs, asynchronous to clk
//   spi_miso, spi_miso_oe : serial read data and its output enable
//   address, data_write_in, write_en, reg_en : register-bus request
//   data_read_out   : bank read data, valid one clk after address/reg_en
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int ADR_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_sclk,
  input  logic                spi_csn,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic [ADR_BITS-1:0] address,
  output logic [7:0]          data_write_in,
  input  logic [7:0]          data_read_out,
  output logic                reg_en,
  output logic                write_en
);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic csn_level, csn_fall, csn_rise_unused;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_csn),
    .level (csn_level),
    .rise  (csn_rise_unused),
    .fall  (csn_fall)
  );

  // MOSI is stable for half an sclk period around the rise, so a plain
  // synchronizer of the same depth keeps it aligned with sclk_rise.
  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  spi_bridge_state_t state_q, state_d;
  logic       armed_q;
  logic [2:0] bit_cnt;
  logic [7:0] cmd_q;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       byte_done_p1;
  logic       rd_cap_p1;
  logic       cmd_valid;

  assign cmd_valid = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && csn_fall) state_d = CMD;
      CMD:     if (byte_done_p1) state_d = ADDR;
      ADDR: begin
        if (byte_done_p1) begin
          if (cmd_q == CMD_WRITE)     state_d = WR_DATA;
          else if (cmd_q == CMD_READ) state_d = RD_DATA;
          else                        state_d = IGNORE;
        end
      end
      default: state_d = state_q;
    endcase
    if (csn_level) state_d = IDLE;
  end

  // Stage p0 -> p1: bit capture on synchronized sclk rise, byte completion flag
  always_ff @(posedge clk) begin
    if (sclk_rise) rx_shift <= {rx_shift[6:0], mosi_s};
  end

  // Stage p1 -> p2: read data lands two clks after the read strobe
  always_ff @(posedge clk) begin
    if (rd_cap_p1)                          tx_shift <= data_read_out;
    else if (sclk_fall && state_q == RD_DATA) tx_shift <= {tx_shift[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      bit_cnt       <= '0;
      cmd_q         <= '0;
      byte_done_p1  <= 1'b0;
      rd_cap_p1     <= 1'b0;
      address       <= '0;
      data_write_in <= '0;
      write_en      <= 1'b0;
      reg_en        <= 1'b0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_en     <= 1'b0;
      reg_en       <= 1'b0;
      byte_done_p1 <= 1'b0;
      rd_cap_p1    <= reg_en & ~write_en;
      // A frame is only accepted after csn has been seen high since reset.
      if (csn_level) armed_q <= 1'b1;
      if (write_en)  address <= address + 1'b1;

      if (state_q == IDLE || csn_level) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt      <= bit_cnt + 3'd1;
        byte_done_p1 <= (bit_cnt == 3'd7);
      end

      if (byte_done_p1 && !csn_level) begin
        case (state_q)
          CMD: cmd_q <= rx_shift;
          ADDR: begin
            if (cmd_valid) begin
              address <= rx_shift[ADR_BITS-1:0];
              reg_en  <= (cmd_q == CMD_READ);
            end
          end
          WR_DATA: begin
            data_write_in <= rx_shift;
            write_en      <= 1'b1;
            reg_en        <= 1'b1;
          end
          // Prefetch the next byte as soon as the current one is shifted out.
          RD_DATA: begin
            address <= address + 1'b1;
            reg_en  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (csn_level || state_q != RD_DATA) begin
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (sclk_fall) begin
        spi_miso    <= tx_shift[7];
        spi_miso_oe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: host-side SPI driver, a registered
// register-bank model and strobe logging.
module tb_spi_reg_bridge;

  localparam int  SYNC = 2;
  localparam time HALF = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_csn, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] address, data_write_in, data_read_out;
  logic       reg_en, write_en;

  logic [7:0] mem [0:255];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] ra_q[$];
  int         reg_cnt = 0;
  int         consec  = 0;
  logic       prev_strobe = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_byte;
  logic       byte_oe_any, byte_oe_all;
  logic       oe_acc;
  time        t0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADR_BITS(8), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_sclk      (spi_sclk),
    .spi_csn       (spi_csn),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .address       (address),
    .data_write_in (data_write_in),
    .data_read_out (data_read_out),
    .reg_en        (reg_en),
    .write_en      (write_en)
  );

  always @(posedge clk) data_read_out <= mem[address];

  always @(posedge clk) begin
    if (write_en) begin
      wa_q.push_back(address);
      wd_q.push_back(data_write_in);
    end
    if (reg_en && !write_en) ra_q.push_back(address);
    if (reg_en) reg_cnt++;
    if (prev_strobe && (reg_en || write_en)) consec++;
    prev_strobe = reg_en || write_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    reg_cnt = 0;
    oe_acc  = 1'b0;
  endtask

  // Shifts the top n bits of b MSB first; samples MISO/OE on each sclk rise.
  task automatic spi_bits(input logic [7:0] b, input int n);
    rx_byte     = 8'h00;
    byte_oe_any = 1'b0;
    byte_oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #HALF;
      spi_sclk    = 1'b1;
      rx_byte     = {rx_byte[6:0], spi_miso};
      byte_oe_any = byte_oe_any | spi_miso_oe;
      byte_oe_all = byte_oe_all & spi_miso_oe;
      #HALF;
      spi_sclk = 1'b0;
    end
    oe_acc = oe_acc | byte_oe_any;
  endtask

  task automatic frame_start();
    spi_csn = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    spi_csn = 1'b1;
    #(4*HALF);
  endtask

  task automatic realign();
    @(posedge clk);
    #5;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h01] = 8'h85;
    mem[8'hFF] = 8'hC6;
    mem[8'h00] = 8'h39;
    reset = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    clear_logs();

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_address", address, 8'h00);
    chk("rst_wdata", data_write_in, 8'h00);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_reg_en", reg_en, 1'b0);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_oe", spi_miso_oe, 1'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #5;

    // Write burst 02 04 A5 5A 3C
    clear_logs();
    frame_start();
    spi_bits(8'h02, 8); spi_bits(8'h04, 8);
    spi_bits(8'hA5, 8); spi_bits(8'h5A, 8); spi_bits(8'h3C, 8);
    frame_end();
    chk("wr_count", wa_q.size(), 3);
    if (wa_q.size() >= 3) begin
      chk("wr0_addr", wa_q[0], 8'h04); chk("wr0_data", wd_q[0], 8'hA5);
      chk("wr1_addr", wa_q[1], 8'h05); chk("wr1_data", wd_q[1], 8'h5A);
      chk("wr2_addr", wa_q[2], 8'h06); chk("wr2_data", wd_q[2], 8'h3C);
    end
    chk("wr_reg_en_count", reg_cnt, 3);
    chk("wr_oe_never", oe_acc, 1'b0);
    chk("wr_addr_after", address, 8'h07);

    // Single read 03 01 -> 85, then OE release timing
    clear_logs();
    frame_start();
    spi_bits(8'h03, 8); spi_bits(8'h01, 8);
    chk("rd_oe_hdr", oe_acc, 1'b0);
    spi_bits(8'h00, 8);
    chk("rd_miso_byte", rx_byte, 8'h85);
    chk("rd_oe_data", byte_oe_all, 1'b1);
    chk("rd_first_addr", (ra_q.size() > 0) ? ra_q[0] : 8'hXX, 8'h01);
    chk("rd_addr1_once", (ra_q.size() > 1) ? (ra_q[1] != 8'h01) : 1'b1, 1'b1);
    chk("rd_no_write", wa_q.size(), 0);
    #HALF;
    spi_csn = 1'b1;
    @(posedge clk);
    repeat (SYNC) @(posedge clk);
    #1 chk("oe_hold_before_release", spi_miso_oe, 1'b1);
    @(posedge clk);
    #1 chk("oe_release", spi_miso_oe, 1'b0);
    realign();
    #(4*HALF);

    // Read burst with wrap: 03 FF + two bytes
    clear_logs();
    frame_start();
    spi_bits(8'h03, 8); spi_bits(8'hFF, 8);
    spi_bits(8'h00, 8);
    chk("wrap_byte0", rx_byte, 8'hC6);
    spi_bits(8'h00, 8);
    chk("wrap_byte1", rx_byte, 8'h39);
    frame_end();
    chk("wrap_rd0_addr", (ra_q.size() > 0) ? ra_q[0] : 8'hXX, 8'hFF);
    chk("wrap_rd1_addr", (ra_q.size() > 1) ? ra_q[1] : 8'hXX, 8'h00);

    // Abort: 02 02 + 5 bits, then a timed write frame 02 20 C3
    clear_logs();
    frame_start();
    spi_bits(8'h02, 8); spi_bits(8'h02, 8); spi_bits(8'hF8, 5);
    frame_end();
    chk("abort_no_write", wa_q.size(), 0);
    chk("abort_no_reg_en", reg_cnt, 0);
    clear_logs();
    frame_start();
    spi_bits(8'h02, 8); spi_bits(8'h20, 8); spi_bits(8'hC3, 7);
    spi_mosi = 1'b1;
    #HALF;
    spi_sclk = 1'b1;
    t0 = $time;
    @(posedge clk);
    repeat (SYNC + 1) @(posedge clk);
    #1 chk("we_not_early", write_en, 1'b0);
    @(posedge clk);
    #1 chk("we_on_time", write_en, 1'b1);
    chk("we_addr", address, 8'h20);
    chk("we_data", data_write_in, 8'hC3);
    @(posedge clk);
    #1 chk("we_one_cycle", write_en, 1'b0);
    #(t0 + HALF - $time);
    spi_sclk = 1'b0;
    frame_end();
    chk("after_abort_count", wa_q.size(), 1);

    // Bad command 7E 00 FF
    clear_logs();
    frame_start();
    spi_bits(8'h7E, 8); spi_bits(8'h00, 8); spi_bits(8'hFF, 8);
    chk("bad_miso", rx_byte, 8'h00);
    frame_end();
    chk("bad_reg_en", reg_cnt, 0);
    chk("bad_write_en", wa_q.size(), 0);
    chk("bad_oe", oe_acc, 1'b0);

    // Reset at bit 12 of a write frame, csn held low
    clear_logs();
    frame_start();
    spi_bits(8'h02, 8); spi_bits(8'h30, 4);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    #5;
    spi_bits(8'h00, 4); spi_bits(8'hAA, 8); spi_bits(8'h55, 8);
    chk("midrst_no_strobe", reg_cnt, 0);
    chk("midrst_address", address, 8'h00);
    frame_end();
    frame_start();
    spi_bits(8'h02, 8); spi_bits(8'h00, 8); spi_bits(8'h11, 8);
    frame_end();
    chk("midrst_wr_count", wa_q.size(), 1);
    chk("midrst_wr_addr", (wa_q.size() > 0) ? wa_q[0] : 8'hXX, 8'h00);
    chk("midrst_wr_data", (wd_q.size() > 0) ? wd_q[0] : 8'hXX, 8'h11);

    chk("no_back_to_back_strobes", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
